// File: rtl/delay_line_ctrl_if.sv
// Sample-strobe / delay-RAM control bundle for delay_line_ctrl.
// master drives the strobe and delay request; slave (the controller) drives the RAM controls.
interface delay_line_ctrl_if #(
  parameter int ADD_WIDTH = 9
);
  logic                 en;
  logic [ADD_WIDTH-1:0] offset;
  logic                 offset_ld;
  logic                 wr;
  logic                 rd;
  logic [ADD_WIDTH-1:0] wr_addr;
  logic [ADD_WIDTH-1:0] rd_addr;
  logic                 valid;
  logic                 busy;

  modport master (
    output en, offset, offset_ld,
    input  wr, rd, wr_addr, rd_addr, valid, busy
  );

  modport slave (
    input  en, offset, offset_ld,
    output wr, rd, wr_addr, rd_addr, valid, busy
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// Circular delay-RAM address controller: write pointer advances per sample, read pointer trails by dly.
// Define DELAY_LINE_CTRL_FILL_EN to gate valid until the line has been primed with dly samples.
module delay_line_ctrl #(
  parameter int ADD_WIDTH = 9
) (
  input logic             clk,
  input logic             rst_n,
  delay_line_ctrl_if.slave bus
);

  localparam logic [ADD_WIDTH-1:0] ONE = ADD_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t               state;
  logic [ADD_WIDTH-1:0] dly;
  logic [ADD_WIDTH-1:0] wr_addr_q;
  logic                 valid_q;
  logic                 wr_en;
  logic [ADD_WIDTH-1:0] ld_dly;

  // A zero delay would read the slot being written; clamp to one sample.
  always_comb begin
    ld_dly = bus.offset;
    if (bus.offset == '0) ld_dly = ONE;
  end

  assign wr_en       = bus.en && (state != IDLE);
  assign bus.wr      = wr_en;
  assign bus.rd      = wr_en;
  assign bus.wr_addr = wr_addr_q;
  assign bus.rd_addr = wr_addr_q - dly;
  assign bus.valid   = valid_q;

`ifdef DELAY_LINE_CTRL_FILL_EN

  logic [ADD_WIDTH-1:0] fcnt;
  logic [ADD_WIDTH-1:0] fcnt_inc;
  logic                 busy_q;

  assign fcnt_inc = fcnt + ONE;
  assign bus.busy = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dly       <= ONE;
      wr_addr_q <= '0;
      fcnt      <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (bus.offset_ld) dly <= ld_dly;
      if (wr_en) wr_addr_q <= wr_addr_q + ONE;
      valid_q <= (state == RUN) && wr_en;

      case (state)
        IDLE: begin
          if (bus.en || bus.offset_ld) begin
            state  <= FILL;
            busy_q <= 1'b1;
            fcnt   <= '0;
          end
        end
        FILL, RUN: begin
          if (bus.offset_ld) begin
            // A sample arriving with the reload is the first one counted against the new delay.
            fcnt <= bus.en ? ONE : '0;
            if (bus.en && (ld_dly == ONE)) begin
              state  <= RUN;
              busy_q <= 1'b0;
            end else begin
              state  <= FILL;
              busy_q <= 1'b1;
            end
          end else if ((state == FILL) && bus.en) begin
            fcnt <= fcnt_inc;
            if (fcnt_inc == dly) begin
              state  <= RUN;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`else

  assign bus.busy = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dly       <= ONE;
      wr_addr_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (bus.offset_ld) dly <= ld_dly;
      if (wr_en) wr_addr_q <= wr_addr_q + ONE;
      valid_q <= (state == RUN) && wr_en;

      case (state)
        IDLE: begin
          if (bus.en || bus.offset_ld) state <= RUN;
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`endif

endmodule

// File: doc/delay_line_ctrl.md
DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

Interface
REQ-001 Parameter ADD_WIDTH, default 9, SHALL set delay-RAM address width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 en  input  1  SHALL be the sample strobe; one new sample per cycle with en=1.
REQ-005 offset  input  ADD_WIDTH  SHALL be the requested delay in samples.
REQ-006 offset_ld  input  1  SHALL be a one-cycle pulse to latch offset.
REQ-007 wr  output  1  SHALL be the RAM write enable.
REQ-008 rd  output  1  SHALL be the RAM read enable.
REQ-009 wr_addr  output  ADD_WIDTH  SHALL be the RAM write address.
REQ-010 rd_addr  output  ADD_WIDTH  SHALL be the RAM read address.
REQ-011 valid  output  1  SHALL flag that the RAM read data on this cycle is a true delayed sample.
REQ-012 busy  output  1  SHALL be high while state is FILL.

Function
REQ-013 State machine SHALL have states IDLE, FILL, RUN.
REQ-014 Delay register dly SHALL latch offset on offset_ld; offset=0 SHALL latch as 1.
REQ-015 wr and rd SHALL equal en combinationally in FILL and RUN, and SHALL be 0 in IDLE.
REQ-016 wr_addr SHALL be a registered counter incremented by 1 on each cycle with wr=1, wrapping from 2^ADD_WIDTH-1 to 0.
REQ-017 rd_addr SHALL equal (wr_addr - dly) modulo 2^ADD_WIDTH, combinational from wr_addr and dly.
REQ-018 Fill counter fcnt (ADD_WIDTH bits) SHALL count written samples in FILL, clearing on entry to FILL.
REQ-019 IDLE -> FILL SHALL occur on the first cycle with en=1 or offset_ld=1.
REQ-020 FILL -> RUN SHALL occur on the cycle in which fcnt reaches dly with en=1.
REQ-021 RUN -> FILL SHALL occur on offset_ld=1; wr_addr SHALL NOT be reset, only fcnt cleared.
REQ-022 offset_ld in FILL SHALL reload dly and clear fcnt, staying in FILL.
REQ-023 valid SHALL be registered: valid = 1 in the cycle after a cycle with rd=1 in RUN, else 0 (matches 1-cycle RAM read latency).
REQ-024 Simultaneous offset_ld and en SHALL write the sample, latch the new dly, and count that sample as fcnt=1.
REQ-025 en=0 SHALL freeze wr_addr, fcnt and state (except offset_ld transitions).

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, wr_addr=0, fcnt=0, dly=1, valid=0, busy=0.
REQ-027 Reset mid-FILL or mid-RUN SHALL discard all progress; restart requires REQ-019 conditions.
REQ-028 Deassertion SHALL take effect on the first posedge clk after rst_n rises.

Configuration
REQ-029 Macro DELAY_LINE_CTRL_FILL_EN SHALL control fill gating.
REQ-030 With DELAY_LINE_CTRL_FILL_EN defined: FILL state and fcnt SHALL exist as above.
REQ-031 Without it: IDLE SHALL go directly to RUN, offset_ld SHALL only reload dly, busy SHALL be tied 0, and valid SHALL follow rd by one cycle from the first sample.

Verification
REQ-032 Reset, offset_ld with offset=4, en=1 continuous -> busy high 4 en-cycles, valid first high 1 cycle after RUN entry, rd_addr = wr_addr - 4.
REQ-033 offset=0 loaded -> dly=1, rd_addr = wr_addr - 1 mod 512.
REQ-034 Run dly=3 past wr_addr=511 -> wr_addr wraps to 0, rd_addr = 509 at wr_addr=0, valid stays high.
REQ-035 In RUN with dly=3, pulse offset_ld offset=10 -> busy high, valid low for 10 en-cycles, wr_addr continues without reset.
REQ-036 en toggled 1,0,1,0 in FILL dly=2 -> wr_addr and fcnt advance only on en=1; RUN entered after 2nd en=1.
REQ-037 rst_n asserted mid-RUN asynchronously -> outputs at reset values before next clock edge; with macro undefined, same stimulus as REQ-032 gives busy=0 and valid one cycle after first en.
